// File: rtl/psum_acc_mem_if.sv
// ----------------------------------------------------------------------------
// psum_acc_mem_if: accumulate/read/clear bus of the partial-sum buffer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface psum_acc_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LANES      = 2
);
  logic                        i_clr;
  logic                        o_busy;
  logic [LANES-1:0]            i_acc_en;
  logic [LANES-1:0]            i_acc_first;
  logic [LANES*ADDR_WIDTH-1:0] i_acc_addr;
  logic [LANES*DATA_WIDTH-1:0] i_acc_data;
  logic                        i_rd_en;
  logic [LANES*ADDR_WIDTH-1:0] i_rd_addr;
  logic                        o_rd_valid;
  logic [LANES*ACC_WIDTH-1:0]  o_rd_data;

  modport master (
    output i_clr, i_acc_en, i_acc_first, i_acc_addr, i_acc_data, i_rd_en, i_rd_addr,
    input  o_busy, o_rd_valid, o_rd_data
  );

  modport slave (
    input  i_clr, i_acc_en, i_acc_first, i_acc_addr, i_acc_data, i_rd_en, i_rd_addr,
    output o_busy, o_rd_valid, o_rd_data
  );
endinterface

`default_nettype wire

// File: rtl/psum_acc_mem.sv
// ----------------------------------------------------------------------------
// psum_acc_mem: multi-lane partial-sum buffer with saturating in-place accumulate.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module psum_acc_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LANES      = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  psum_acc_mem_if.slave        bus
);

  localparam int SUM_W = ACC_WIDTH + $clog2(LANES + 1) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                       state;
  logic [ADDR_WIDTH-1:0]        cnt;
  logic                         busy;

  logic signed [ACC_WIDTH-1:0]  mem [DEPTH];

  logic [LANES-1:0]             st_en;
  logic [LANES-1:0]             st_first;
  logic [ADDR_WIDTH-1:0]        st_addr [LANES];
  logic signed [DATA_WIDTH-1:0] st_data [LANES];

  logic                         rq_en;
  logic [ADDR_WIDTH-1:0]        rq_addr [LANES];
  logic                         rd_valid;
  logic [LANES*ACC_WIDTH-1:0]   rd_data;

  logic [LANES-1:0]             wr_lead;
  logic [LANES-1:0]             grp_first;
  logic signed [SUM_W-1:0]      sum    [LANES];
  logic signed [ACC_WIDTH-1:0]  wr_val [LANES];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.i_clr) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          busy  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_en    <= '0;
      st_first <= '0;
      rq_en    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      for (int k = 0; k < LANES; k++) begin
        st_addr[k] <= '0;
        st_data[k] <= '0;
        rq_addr[k] <= '0;
      end
    end else begin
      st_en    <= busy ? '0 : bus.i_acc_en;
      st_first <= bus.i_acc_first;
      rq_en    <= bus.i_rd_en && !busy;
      rd_valid <= rq_en;
      for (int k = 0; k < LANES; k++) begin
        st_addr[k] <= bus.i_acc_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        st_data[k] <= bus.i_acc_data[k*DATA_WIDTH +: DATA_WIDTH];
        rq_addr[k] <= bus.i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
      // Memory is read a cycle after sampling, so commits from the sample edge are already visible.
      if (rq_en) begin
        for (int k = 0; k < LANES; k++) begin
          rd_data[k*ACC_WIDTH +: ACC_WIDTH] <= in_range(rq_addr[k]) ? mem[rq_addr[k]] : '0;
        end
      end
    end
  end

  // Colliding lanes merge into a single write owned by the lowest-index lane of the group.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      wr_lead[k]   = st_en[k] && !busy && in_range(st_addr[k]);
      sum[k]       = '0;
      grp_first[k] = 1'b0;
      for (int j = 0; j < LANES; j++) begin
        if (st_en[j] && (st_addr[j] == st_addr[k])) begin
          sum[k]       = sum[k] + SUM_W'(st_data[j]);
          grp_first[k] = grp_first[k] | st_first[j];
          if (j < k) begin
            wr_lead[k] = 1'b0;
          end
        end
      end
      if (!grp_first[k]) begin
        sum[k] = sum[k] + SUM_W'(mem[st_addr[k]]);
      end
      if (sum[k] > SAT_MAX) begin
        wr_val[k] = SAT_MAX[ACC_WIDTH-1:0];
      end else if (sum[k] < SAT_MIN) begin
        wr_val[k] = SAT_MIN[ACC_WIDTH-1:0];
      end else begin
        wr_val[k] = sum[k][ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_lead[k]) begin
          mem[st_addr[k]] <= wr_val[k];
        end
      end
    end
  end

  assign bus.o_busy     = busy;
  assign bus.o_rd_valid = rd_valid;
  assign bus.o_rd_data  = rd_data;

endmodule

`default_nettype wire

// File: tb/tb_psum_acc_mem.sv
// ----------------------------------------------------------------------------
// tb_psum_acc_mem: directed self-checking bench for psum_acc_mem.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_psum_acc_mem;

  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 24;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int LANES      = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  psum_acc_mem_if #(
    .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH), .LANES(LANES)
  ) bus ();

  psum_acc_mem #(
    .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH), .LANES(LANES)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  task automatic set_idle();
    bus.i_clr       = 1'b0;
    bus.i_acc_en    = '0;
    bus.i_acc_first = '0;
    bus.i_acc_addr  = '0;
    bus.i_acc_data  = '0;
    bus.i_rd_en     = 1'b0;
    bus.i_rd_addr   = '0;
  endtask

  task automatic cyc_acc(input logic [1:0] en, input logic [1:0] first,
                         input logic [3:0] a0, input logic [7:0] d0,
                         input logic [3:0] a1, input logic [7:0] d1);
    @(negedge clk);
    set_idle();
    bus.i_acc_en    = en;
    bus.i_acc_first = first;
    bus.i_acc_addr  = {a1, a0};
    bus.i_acc_data  = {d1, d0};
  endtask

  task automatic read2(input logic [3:0] a0, input logic [3:0] a1,
                       output logic [23:0] d0, output logic [23:0] d1, output logic v);
    @(negedge clk);
    set_idle();
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = {a1, a0};
    @(negedge clk);
    bus.i_rd_en = 1'b0;
    @(negedge clk);
    v  = bus.o_rd_valid;
    d0 = bus.o_rd_data[23:0];
    d1 = bus.o_rd_data[47:24];
  endtask

  task automatic test_reset();
    logic [23:0] d0, d1;
    logic        v;
    int          cnt;
    rst_n = 1'b0;
    set_idle();
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", bus.o_busy); end
    n_checks++;
    if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_rd_valid); end
    n_checks++;
    if (bus.o_rd_data !== 48'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.o_rd_data); end
    rst_n = 1'b1;
    cnt = 0;
    while (bus.o_busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt !== 16) begin n_fail++; $display("FAIL reset_sweep_len got %0d want 16", cnt); end
    for (int i = 0; i < 16; i++) begin
      read2(4'(i), 4'(15 - i), d0, d1, v);
      n_checks++;
      if (v !== 1'b1) begin n_fail++; $display("FAIL reset_rd_valid addr %0d got %b want 1", i, v); end
      n_checks++;
      if (d0 !== 24'h0 || d1 !== 24'h0) begin
        n_fail++; $display("FAIL reset_word addr %0d got %h/%h want 0/0", i, d0, d1);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [23:0] d0, d1;
    logic        v;
    cyc_acc(2'b01, 2'b00, 4'd3, 8'd5,   4'd0, 8'd0);
    cyc_acc(2'b01, 2'b00, 4'd3, 8'hFE,  4'd0, 8'd0);
    read2(4'd3, 4'd3, d0, d1, v);
    n_checks++;
    if (v !== 1'b1 || d0 !== 24'd3 || d1 !== 24'd3) begin
      n_fail++; $display("FAIL back_to_back got v=%b %h/%h want 1 000003/000003", v, d0, d1);
    end
  endtask

  task automatic test_collision();
    logic [23:0] d0, d1;
    logic        v;
    cyc_acc(2'b01, 2'b01, 4'd4, 8'd10, 4'd0, 8'd0);
    cyc_acc(2'b11, 2'b00, 4'd4, 8'd7,  4'd4, 8'd9);
    read2(4'd4, 4'd0, d0, d1, v);
    n_checks++;
    if (d0 !== 24'd26) begin n_fail++; $display("FAIL collision_add got %0d want 26", d0); end
    cyc_acc(2'b11, 2'b10, 4'd4, 8'd7,  4'd4, 8'd9);
    read2(4'd4, 4'd0, d0, d1, v);
    n_checks++;
    if (d0 !== 24'd16) begin n_fail++; $display("FAIL collision_first got %0d want 16", d0); end
  endtask

  task automatic test_saturation();
    logic [23:0] d0, d1;
    logic        v;
    for (int i = 0; i < 33026; i++) cyc_acc(2'b11, 2'b00, 4'd5, 8'd127, 4'd5, 8'd127);
    cyc_acc(2'b01, 2'b00, 4'd5, 8'hFC, 4'd0, 8'd0);
    read2(4'd5, 4'd5, d0, d1, v);
    n_checks++;
    if (d0 !== 24'h7FFFF8) begin n_fail++; $display("FAIL sat_preset_pos got %h want 7ffff8", d0); end
    cyc_acc(2'b01, 2'b00, 4'd5, 8'd127, 4'd0, 8'd0);
    read2(4'd5, 4'd5, d0, d1, v);
    n_checks++;
    if (d0 !== 24'h7FFFFF || d1 !== 24'h7FFFFF) begin
      n_fail++; $display("FAIL sat_pos got %h/%h want 7fffff", d0, d1);
    end
    for (int i = 0; i < 32767; i++) cyc_acc(2'b11, 2'b00, 4'd6, 8'h80, 4'd6, 8'h80);
    cyc_acc(2'b11, 2'b00, 4'd6, 8'h80, 4'd6, 8'h88);
    read2(4'd6, 4'd6, d0, d1, v);
    n_checks++;
    if (d0 !== 24'h800008) begin n_fail++; $display("FAIL sat_preset_neg got %h want 800008", d0); end
    cyc_acc(2'b01, 2'b00, 4'd6, 8'h80, 4'd0, 8'd0);
    read2(4'd6, 4'd6, d0, d1, v);
    n_checks++;
    if (d0 !== 24'h800000) begin n_fail++; $display("FAIL sat_neg got %h want 800000", d0); end
  endtask

  task automatic test_read_timing();
    cyc_acc(2'b01, 2'b01, 4'd2, 8'd40, 4'd0, 8'd0);
    @(negedge clk);
    set_idle();
    bus.i_acc_en   = 2'b01;
    bus.i_acc_addr = {4'd0, 4'd2};
    bus.i_acc_data = {8'd0, 8'd1};
    bus.i_rd_en    = 1'b1;
    bus.i_rd_addr  = {4'd2, 4'd2};
    @(negedge clk);
    bus.i_acc_en = '0;
    @(negedge clk);
    bus.i_rd_en = 1'b0;
    n_checks++;
    if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== {24'd40, 24'd40}) begin
      n_fail++; $display("FAIL read_same_cycle got v=%b %h want 1 both 40", bus.o_rd_valid, bus.o_rd_data);
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== {24'd41, 24'd41}) begin
      n_fail++; $display("FAIL read_next_cycle got v=%b %h want 1 both 41", bus.o_rd_valid, bus.o_rd_data);
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_rd_valid !== 1'b0 || bus.o_rd_data !== {24'd41, 24'd41}) begin
      n_fail++; $display("FAIL read_hold got v=%b %h want 0 both 41", bus.o_rd_valid, bus.o_rd_data);
    end
  endtask

  task automatic test_clear();
    logic [23:0] d0, d1;
    logic        v;
    int          cnt;
    int          bad_valid;
    cyc_acc(2'b01, 2'b01, 4'd8, 8'd3, 4'd0, 8'd0);
    @(negedge clk);
    set_idle();
    bus.i_clr = 1'b1;
    @(negedge clk);
    cnt = 0;
    bad_valid = 0;
    while (bus.o_busy === 1'b1 && cnt < 40) begin
      if (bus.o_rd_valid !== 1'b0) bad_valid++;
      bus.i_clr       = 1'b1;
      bus.i_acc_en    = 2'b11;
      bus.i_acc_first = 2'b00;
      bus.i_acc_addr  = {4'd9, 4'd9};
      bus.i_acc_data  = {8'd5, 8'd5};
      bus.i_rd_en     = 1'b1;
      bus.i_rd_addr   = {4'd9, 4'd8};
      cnt++;
      @(negedge clk);
    end
    set_idle();
    n_checks++;
    if (cnt !== 16) begin n_fail++; $display("FAIL clear_sweep_len got %0d want 16", cnt); end
    n_checks++;
    if (bad_valid !== 0) begin n_fail++; $display("FAIL clear_rd_valid got %0d pulses want 0", bad_valid); end
    @(negedge clk);
    n_checks++;
    if (bus.o_rd_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL clear_tail got v=%b busy=%b want 0/0", bus.o_rd_valid, bus.o_busy);
    end
    for (int i = 0; i < 8; i++) begin
      read2(4'(i), 4'(i + 8), d0, d1, v);
      n_checks++;
      if (v !== 1'b1 || d0 !== 24'h0 || d1 !== 24'h0) begin
        n_fail++; $display("FAIL clear_word addr %0d/%0d got v=%b %h/%h want 1 0/0", i, i + 8, v, d0, d1);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [23:0] d0, d1;
    logic        v;
    int          cnt;
    cyc_acc(2'b01, 2'b01, 4'd12, 8'd5, 4'd0, 8'd0);
    @(negedge clk);
    set_idle();
    bus.i_clr = 1'b1;
    @(negedge clk);
    bus.i_clr = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++;
    if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_sweep_busy got %b want 1", bus.o_busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (bus.o_busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt !== 16) begin n_fail++; $display("FAIL restart_sweep_len got %0d want 16", cnt); end
    read2(4'd12, 4'd0, d0, d1, v);
    n_checks++;
    if (v !== 1'b1 || d0 !== 24'h0 || d1 !== 24'h0) begin
      n_fail++; $display("FAIL restart_word got v=%b %h/%h want 1 0/0", v, d0, d1);
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_collision();
    test_saturation();
    test_read_timing();
    test_clear();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
